amplitude_ramp_controller: RTL and testbench

- Sequences the four amplitude inputs of the Fourier synthesizer with a soft start and stop.
- On enable, all four channel amplitudes ramp linearly from 0 to their configured targets, hold there, and ramp back to 0 on disable.
- The block sits between the AXI configuration registers (targets, ramp settings, enable) and the synthesizer amplitude inputs. This avoids DAC steps when the excitation is switched.
- A single multiplier is time-shared across the four channels.

---
 rtl/amplitude_ramp_controller_pkg.sv | 37 +++
 rtl/amplitude_ramp_controller_scaler.sv | 68 ++++++
 rtl/amplitude_ramp_controller.sv | 137 +++++++++++++
 tb/tb_amplitude_ramp_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/amplitude_ramp_controller_pkg.sv
// Shared types and constants for the amplitude ramp controller and its scaler.
// The ramp factor is a 17-bit unsigned value where FACTOR_ONE represents unity gain.
package amplitude_ramp_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;

  localparam int FACTOR_WIDTH = 17;
  localparam int INC_WIDTH    = 16;
  localparam int N_CHANNELS   = 4;
  localparam logic [FACTOR_WIDTH-1:0] FACTOR_ONE = 17'd65536;

  // Saturating factor step towards unity
  function automatic logic [FACTOR_WIDTH-1:0] factor_step_up(
    input logic [FACTOR_WIDTH-1:0] f,
    input logic [INC_WIDTH-1:0]    inc
  );
    logic [FACTOR_WIDTH:0] sum;
    sum = {1'b0, f} + {2'b00, inc};
    return (sum >= {1'b0, FACTOR_ONE}) ? FACTOR_ONE : sum[FACTOR_WIDTH-1:0];
  endfunction

  // Saturating factor step towards zero
  function automatic logic [FACTOR_WIDTH-1:0] factor_step_down(
    input logic [FACTOR_WIDTH-1:0] f,
    input logic [INC_WIDTH-1:0]    inc
  );
    logic [FACTOR_WIDTH-1:0] inc_w;
    inc_w = {1'b0, inc};
    return (f > inc_w) ? (f - inc_w) : '0;
  endfunction

endpackage

// File: rtl/amplitude_ramp_controller_scaler.sv
// Round-robin scaler: one multiplier serves all channels, outputs commit together.
// Slot 0 snapshots the factor and targets so a committed set never mixes two factors.
module amplitude_scaler
  import amplitude_ramp_controller_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic [FACTOR_WIDTH-1:0]          i_factor,
  input  logic [N_CHANNELS-1:0][W-1:0]     i_targets,
  output logic [N_CHANNELS-1:0][W-1:0]     o_amplitudes
);

  localparam int SLOT_WIDTH = $clog2(N_CHANNELS);
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(N_CHANNELS - 1);

  logic [SLOT_WIDTH-1:0]               r_slot;
  logic [FACTOR_WIDTH-1:0]             r_factor_snap;
  logic [N_CHANNELS-2:0][W-1:0]        r_target_snap;
  logic [N_CHANNELS-2:0][W-1:0]        r_shadow;
  logic [N_CHANNELS-1:0][W-1:0]        r_amp;

  logic [W-1:0]                        w_op_target;
  logic [FACTOR_WIDTH-1:0]             w_op_factor;
  logic [W+FACTOR_WIDTH-1:0]           w_product;
  logic [W-1:0]                        w_scaled;
  logic [SLOT_WIDTH-1:0]               w_snap_idx;

  assign w_snap_idx = r_slot - SLOT_WIDTH'(1);

  // Slot 0 works on the live inputs, which are captured in the same cycle
  always_comb begin
    w_op_target = i_targets[0];
    w_op_factor = i_factor;
    if (r_slot != '0) begin
      w_op_target = r_target_snap[w_snap_idx];
      w_op_factor = r_factor_snap;
    end
  end

  assign w_product = {{FACTOR_WIDTH{1'b0}}, w_op_target} * {{W{1'b0}}, w_op_factor};
  assign w_scaled  = W'(w_product >> (FACTOR_WIDTH - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_slot        <= '0;
      r_factor_snap <= '0;
      r_target_snap <= '0;
      r_shadow      <= '0;
      r_amp         <= '0;
    end else begin
      r_slot <= r_slot + SLOT_WIDTH'(1);
      if (r_slot == '0) begin
        r_factor_snap <= i_factor;
        r_target_snap <= i_targets[N_CHANNELS-1:1];
      end
      if (r_slot == LAST_SLOT) begin
        r_amp <= {w_scaled, r_shadow};
      end else begin
        r_shadow[r_slot] <= w_scaled;
      end
    end
  end

  assign o_amplitudes = r_amp;

endmodule

// File: rtl/amplitude_ramp_controller.sv
// Soft start/stop sequencer for the four synthesizer amplitudes.
// Holds the ramp FSM, the tick timer and the factor arithmetic; scaling is delegated.
module amplitude_ramp_controller
  import amplitude_ramp_controller_pkg::*;
#(
  parameter int CFG_DATA_WIDTH = 16,
  parameter int PERIOD_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic [CFG_DATA_WIDTH-1:0] target_channel_1,
  input  logic [CFG_DATA_WIDTH-1:0] target_channel_2,
  input  logic [CFG_DATA_WIDTH-1:0] target_channel_3,
  input  logic [CFG_DATA_WIDTH-1:0] target_channel_4,
  input  logic [INC_WIDTH-1:0]      ramp_increment,
  input  logic [PERIOD_WIDTH-1:0]   ramp_period,
  output logic [CFG_DATA_WIDTH-1:0] amplitude_channel_1,
  output logic [CFG_DATA_WIDTH-1:0] amplitude_channel_2,
  output logic [CFG_DATA_WIDTH-1:0] amplitude_channel_3,
  output logic [CFG_DATA_WIDTH-1:0] amplitude_channel_4,
  output logic [1:0]                ramp_state,
  output logic                      ramp_done
);

  ramp_state_e               r_state, w_state_nxt;
  logic [FACTOR_WIDTH-1:0]   r_factor, w_factor_nxt;
  logic [PERIOD_WIDTH-1:0]   r_timer, w_timer_nxt;
  logic                      r_done, w_done_nxt;

  logic [PERIOD_WIDTH-1:0]   w_period_last;
  logic [PERIOD_WIDTH-1:0]   w_timer_adv;
  logic                      w_tick;
  logic                      w_inc_zero;
  logic [FACTOR_WIDTH-1:0]   w_factor_up;
  logic [FACTOR_WIDTH-1:0]   w_factor_down;

  logic [N_CHANNELS-1:0][CFG_DATA_WIDTH-1:0] w_targets;
  logic [N_CHANNELS-1:0][CFG_DATA_WIDTH-1:0] w_amplitudes;

  // A period of 0 is treated as 1; >= keeps a shortened period from overrunning
  assign w_period_last = (ramp_period == '0) ? '0 : (ramp_period - PERIOD_WIDTH'(1));
  assign w_tick        = (r_timer >= w_period_last);
  assign w_timer_adv   = w_tick ? '0 : (r_timer + PERIOD_WIDTH'(1));
  assign w_inc_zero    = (ramp_increment == '0);
  assign w_factor_up   = factor_step_up(r_factor, ramp_increment);
  assign w_factor_down = factor_step_down(r_factor, ramp_increment);

  always_comb begin
    w_state_nxt  = r_state;
    w_factor_nxt = r_factor;
    w_timer_nxt  = r_timer;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_factor_nxt = '0;
        w_timer_nxt  = '0;
        if (enable) begin
          w_state_nxt = RAMP_UP;
          if (w_inc_zero) w_factor_nxt = FACTOR_ONE;
        end
      end
      RAMP_UP: begin
        w_timer_nxt = w_timer_adv;
        // Terminal transition has priority over an enable reversal
        if (w_inc_zero || (w_tick && (w_factor_up == FACTOR_ONE))) begin
          w_factor_nxt = FACTOR_ONE;
          w_state_nxt  = HOLD;
          w_done_nxt   = 1'b1;
        end else if (!enable) begin
          w_state_nxt = RAMP_DOWN;
        end else if (w_tick) begin
          w_factor_nxt = w_factor_up;
        end
      end
      HOLD: begin
        w_factor_nxt = FACTOR_ONE;
        w_timer_nxt  = '0;
        if (!enable) begin
          w_state_nxt = RAMP_DOWN;
          if (w_inc_zero) w_factor_nxt = '0;
        end
      end
      RAMP_DOWN: begin
        w_timer_nxt = w_timer_adv;
        if (w_inc_zero || (w_tick && (w_factor_down == '0))) begin
          w_factor_nxt = '0;
          w_state_nxt  = IDLE;
          w_done_nxt   = 1'b1;
        end else if (enable) begin
          w_state_nxt = RAMP_UP;
        end else if (w_tick) begin
          w_factor_nxt = w_factor_down;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_factor_nxt = '0;
        w_timer_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_factor <= '0;
      r_timer  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_factor <= w_factor_nxt;
      r_timer  <= w_timer_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign w_targets = {target_channel_4, target_channel_3, target_channel_2, target_channel_1};

  amplitude_scaler #(
    .W (CFG_DATA_WIDTH)
  ) u_scaler (
    .clk          (clk),
    .aresetn      (aresetn),
    .i_factor     (r_factor),
    .i_targets    (w_targets),
    .o_amplitudes (w_amplitudes)
  );

  assign amplitude_channel_1 = w_amplitudes[0];
  assign amplitude_channel_2 = w_amplitudes[1];
  assign amplitude_channel_3 = w_amplitudes[2];
  assign amplitude_channel_4 = w_amplitudes[3];
  assign ramp_state          = r_state;
  assign ramp_done           = r_done;

endmodule

// File: tb/tb_amplitude_ramp_controller.sv
// Scoreboard bench for amplitude_ramp_controller: stimulus pushes expected output
// sets {ch4,ch3,ch2,ch1}; a monitor pops one entry per observed output change.
module tb_amplitude_ramp_controller;
  import amplitude_ramp_controller_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [W-1:0]  t1, t2, t3, t4;
  logic [15:0]   inc;
  logic [31:0]   period;
  logic [W-1:0]  a1, a2, a3, a4;
  logic [1:0]    ramp_state;
  logic          ramp_done;

  amplitude_ramp_controller #(.CFG_DATA_WIDTH(W), .PERIOD_WIDTH(32)) dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .enable              (enable),
    .target_channel_1    (t1),
    .target_channel_2    (t2),
    .target_channel_3    (t3),
    .target_channel_4    (t4),
    .ramp_increment      (inc),
    .ramp_period         (period),
    .amplitude_channel_1 (a1),
    .amplitude_channel_2 (a2),
    .amplitude_channel_3 (a3),
    .amplitude_channel_4 (a4),
    .ramp_state          (ramp_state),
    .ramp_done           (ramp_done)
  );

  // ---------------- clock / reset ----------------
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (ramp_done) done_cnt <= done_cnt + 1;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [63:0] mon_prev = '0;
  wire  [63:0] w_cur = {a4, a3, a2, a1};
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en && (w_cur != mon_prev)) begin
      if (exp_q.size() == 0) check("unexpected_commit", w_cur, mon_prev);
      else check("commit", w_cur, exp_q.pop_front());
    end
    mon_prev <= w_cur;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [1:0] tgt, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ramp_state == tgt) break;
    end
    check(name, 64'(ramp_state), 64'(tgt));
  endtask

  task automatic wait_q_empty(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    logic [W-1:0] max1;
    aresetn = 1'b1;
    enable  = 1'b0;
    t1 = 16'h8000; t2 = 16'h4000; t3 = 16'hFFFF; t4 = 16'h0000;
    inc = 16'h4000; period = 32'd10;
    #1 aresetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", w_cur, 64'd0);
    check("rst_state", 64'(ramp_state), 64'(IDLE));
    check("rst_done", 64'(ramp_done), 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Basic ramp up
    exp_q.push_back({16'h0000, 16'h3FFF, 16'h1000, 16'h2000});
    exp_q.push_back({16'h0000, 16'h7FFF, 16'h2000, 16'h4000});
    exp_q.push_back({16'h0000, 16'hBFFF, 16'h3000, 16'h6000});
    exp_q.push_back({16'h0000, 16'hFFFF, 16'h4000, 16'h8000});
    enable = 1'b1;
    wait_state(RAMP_UP, 4, "up_enter");
    wait_state(HOLD, 60, "up_hold");
    check("up_done_pulse", 64'(ramp_done), 64'd1);
    wait_q_empty(20, "up_drain");
    check("up_done_cnt", 64'(done_cnt), 64'd1);
    check("up_ch3_full", 64'(a3), 64'hFFFF);

    // Ramp down
    exp_q.push_back({16'h0000, 16'hBFFF, 16'h3000, 16'h6000});
    exp_q.push_back({16'h0000, 16'h7FFF, 16'h2000, 16'h4000});
    exp_q.push_back({16'h0000, 16'h3FFF, 16'h1000, 16'h2000});
    exp_q.push_back(64'd0);
    enable = 1'b0;
    wait_state(IDLE, 60, "down_idle");
    check("down_done_pulse", 64'(ramp_done), 64'd1);
    wait_q_empty(20, "down_drain");
    check("down_done_cnt", 64'(done_cnt), 64'd2);
    check("down_outputs_zero", w_cur, 64'd0);

    // Reversal at f=0x8000, then resume upwards from f=0x4000
    exp_q.push_back({16'h0000, 16'h3FFF, 16'h1000, 16'h2000});
    exp_q.push_back({16'h0000, 16'h7FFF, 16'h2000, 16'h4000});
    exp_q.push_back({16'h0000, 16'h3FFF, 16'h1000, 16'h2000});
    exp_q.push_back({16'h0000, 16'h7FFF, 16'h2000, 16'h4000});
    exp_q.push_back({16'h0000, 16'hBFFF, 16'h3000, 16'h6000});
    exp_q.push_back({16'h0000, 16'hFFFF, 16'h4000, 16'h8000});
    enable = 1'b1;
    wait_state(RAMP_UP, 4, "rev_up");
    repeat (24) @(negedge clk);
    enable = 1'b0;
    wait_state(RAMP_DOWN, 2, "rev_down");
    repeat (9) @(negedge clk);
    enable = 1'b1;
    wait_state(RAMP_UP, 2, "rev_up_again");
    wait_state(HOLD, 60, "rev_hold");
    wait_q_empty(20, "rev_drain");
    check("rev_done_cnt", 64'(done_cnt), 64'd3);

    // Target change in HOLD: both changed channels must commit together
    exp_q.push_back({16'h0100, 16'hFFFF, 16'h1234, 16'h8000});
    t2 = 16'h1234; t4 = 16'h0100;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (a2 == 16'h1234) break;
    end
    check("tgt_latency_le8", 64'((cyc - t0) <= 8), 64'd1);
    check("tgt_ch4_same_cycle", 64'(a4), 64'h0100);
    wait_q_empty(10, "tgt_drain");

    // Instant step with zero increment
    inc = 16'h0000;
    exp_q.push_back(64'd0);
    enable = 1'b0;
    wait_state(IDLE, 4, "inst_idle");
    wait_q_empty(20, "inst_down_drain");
    exp_q.push_back({16'h0100, 16'hFFFF, 16'h1234, 16'h8000});
    enable = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (a1 == 16'h8000) break;
    end
    check("inst_latency_le8", 64'((cyc - t0) <= 8), 64'd1);
    wait_state(HOLD, 4, "inst_hold");
    wait_q_empty(10, "inst_up_drain");
    exp_q.push_back(64'd0);
    enable = 1'b0;
    wait_state(IDLE, 4, "inst_idle2");
    wait_q_empty(20, "inst_down2_drain");

    // Saturation: 0xC000 per tick, period 1 reaches unity on the second tick
    mon_en = 1'b0;
    inc = 16'hC000; period = 32'd1;
    enable = 1'b1;
    @(negedge clk);
    check("sat_state_e0", 64'(ramp_state), 64'(RAMP_UP));
    @(negedge clk);
    check("sat_state_e1", 64'(ramp_state), 64'(RAMP_UP));
    @(negedge clk);
    check("sat_state_e2", 64'(ramp_state), 64'(HOLD));
    check("sat_done_pulse", 64'(ramp_done), 64'd1);
    max1 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a1 > max1) max1 = a1;
    end
    check("sat_ch1_max", 64'(max1), 64'h8000);
    check("sat_outputs", w_cur, {16'h0100, 16'hFFFF, 16'h1234, 16'h8000});
    check("sat_done_cnt", 64'(done_cnt), 64'd7);

    // Async reset in the middle of RAMP_UP
    inc = 16'h0000;
    enable = 1'b0;
    wait_state(IDLE, 4, "rst_setup_idle");
    inc = 16'h4000; period = 32'd10;
    enable = 1'b1;
    wait_state(RAMP_UP, 4, "rst_setup_up");
    repeat (18) @(negedge clk);
    check("rst_pre_ch1", 64'(a1), 64'h2000);
    #2 aresetn = 1'b0;
    #1;
    check("rst_async_outputs", w_cur, 64'd0);
    check("rst_async_state", 64'(ramp_state), 64'(IDLE));
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    mon_en = 1'b1;
    exp_q.push_back({16'h0040, 16'h3FFF, 16'h048D, 16'h2000});
    @(negedge clk);
    check("rst_restart_state", 64'(ramp_state), 64'(RAMP_UP));
    wait_q_empty(30, "rst_restart_drain");
    mon_en = 1'b0;

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
